// File: rtl/alu_stack_ctrl.sv
// alu_stack_ctrl: operand-stack controller that drives an external alu16b.
// Accepts PUSH/POP/ALU commands over valid/ready. An ALU command pops two
// operands, runs them through the ALU and pushes the result back.
// Optional macro ALU_OVFLW_TRAP_EN: ADD/SUB results that overflow are not
// written back; the operands stay on the stack and sticky err_ovflw is set.
module alu_stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int SPW   = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd,
    input  logic [1:0]     cmd_aluop,
    input  logic [15:0]    cmd_data,
    output logic           rsp_valid,
    output logic [15:0]    rsp_data,
    output logic [15:0]    alu_a,
    output logic [15:0]    alu_b,
    output logic [1:0]     alu_op,
    input  logic [15:0]    alu_r,
    input  logic           alu_ovflw,
    input  logic           alu_zero,
    output logic           flag_ovflw,
    output logic           flag_zero,
    output logic           err_full,
    output logic           err_empty,
`ifdef ALU_OVFLW_TRAP_EN
    output logic           err_ovflw,
`endif
    output logic [SPW-1:0] depth
);

    localparam int AW = SPW - 1;

    localparam logic [1:0] CMD_PUSH = 2'd0;
    localparam logic [1:0] CMD_POP  = 2'd1;
    localparam logic [1:0] CMD_ALU  = 2'd2;

    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, WRITE} state_t;

    state_t          state, state_nx;
    logic [15:0]     stack [DEPTH];
    logic [SPW-1:0]  sp, sp_m1;
    logic [AW-1:0]   idx_m2;
    logic [15:0]     r_q;
    logic            accept, alu_go;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign alu_go    = accept && (cmd == CMD_ALU) && (sp >= SPW'(2));
    assign sp_m1     = sp - SPW'(1);
    assign idx_m2    = AW'(sp - SPW'(2));
    assign depth     = sp;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: an ALU command walks LOAD -> EXEC -> WRITE and back to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (alu_go) state_nx = LOAD;
            LOAD:    state_nx = EXEC;
            EXEC:    state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stack, pointer, ALU interface registers, responses, flags and errors
    always_ff @(posedge clk) begin
        if (reset) begin
            sp         <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            r_q        <= '0;
            flag_ovflw <= 1'b0;
            flag_zero  <= 1'b0;
            err_full   <= 1'b0;
            err_empty  <= 1'b0;
`ifdef ALU_OVFLW_TRAP_EN
            err_ovflw  <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd)
                            CMD_PUSH: begin
                                if (sp < SPW'(DEPTH)) begin
                                    stack[sp[AW-1:0]] <= cmd_data;
                                    sp                <= sp + SPW'(1);
                                end else begin
                                    err_full <= 1'b1;
                                end
                            end
                            CMD_POP: begin
                                if (sp != '0) begin
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= stack[sp_m1[AW-1:0]];
                                    sp        <= sp_m1;
                                end else begin
                                    err_empty <= 1'b1;
                                end
                            end
                            CMD_ALU: begin
                                if (alu_go) begin
                                    alu_a  <= stack[idx_m2];
                                    alu_b  <= stack[sp_m1[AW-1:0]];
                                    alu_op <= cmd_aluop;
                                end else begin
                                    err_empty <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                EXEC: begin
                    r_q        <= alu_r;
                    flag_ovflw <= alu_ovflw;
                    flag_zero  <= alu_zero;
                end
                WRITE: begin
`ifdef ALU_OVFLW_TRAP_EN
                    if (flag_ovflw && (alu_op == OP_ADD || alu_op == OP_SUB)) begin
                        err_ovflw <= 1'b1;
                    end else begin
                        stack[idx_m2] <= r_q;
                        sp            <= sp_m1;
                        rsp_valid     <= 1'b1;
                        rsp_data      <= r_q;
                    end
`else
                    stack[idx_m2] <= r_q;
                    sp            <= sp_m1;
                    rsp_valid     <= 1'b1;
                    rsp_data      <= r_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Bench for alu_stack_ctrl: a behavioural alu16b stand-in, a transaction-level
// reference model (queue stack, busy countdown), a per-cycle compare process,
// and directed literal checks from the test plan followed by random traffic.
module tb_alu_stack_ctrl;

    localparam int DEPTH = 16;
    localparam int SPW   = 5;
`ifdef ALU_OVFLW_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd;
    logic [1:0]     cmd_aluop;
    logic [15:0]    cmd_data;
    logic           rsp_valid;
    logic [15:0]    rsp_data;
    logic [15:0]    alu_a, alu_b;
    logic [1:0]     alu_op;
    logic [15:0]    alu_r;
    logic           alu_ovflw, alu_zero;
    logic           flag_ovflw, flag_zero, err_full, err_empty;
`ifdef ALU_OVFLW_TRAP_EN
    logic           err_ovflw;
`endif
    logic [SPW-1:0] depth;

    always #5 clk = ~clk;

    alu_stack_ctrl #(.DEPTH(DEPTH), .SPW(SPW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .cmd_aluop(cmd_aluop), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_ovflw(alu_ovflw), .alu_zero(alu_zero),
        .flag_ovflw(flag_ovflw), .flag_zero(flag_zero),
        .err_full(err_full), .err_empty(err_empty),
`ifdef ALU_OVFLW_TRAP_EN
        .err_ovflw(err_ovflw),
`endif
        .depth(depth)
    );

    // alu16b stand-in, bit-level (sign-bit overflow rule)
    logic [15:0] alu_d;
    always_comb begin
        alu_r     = '0;
        alu_ovflw = 1'b0;
        alu_d     = alu_a - alu_b;
        case (alu_op)
            2'd0: alu_r = alu_a | alu_b;
            2'd1: begin
                alu_r     = alu_a + alu_b;
                alu_ovflw = (alu_a[15] == alu_b[15]) && (alu_r[15] != alu_a[15]);
            end
            2'd2: begin
                alu_r     = alu_d;
                alu_ovflw = (alu_a[15] != alu_b[15]) && (alu_d[15] != alu_a[15]);
            end
            default: begin
                alu_ovflw = (alu_a[15] != alu_b[15]) && (alu_d[15] != alu_a[15]);
                alu_r     = {15'd0, alu_d[15] ^ alu_ovflw};
            end
        endcase
        alu_zero = (alu_r == 16'd0);
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU using integer arithmetic and range tests
    function automatic void ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic ov);
        int sa, sb, res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = '0;
        ov = 1'b0;
        case (op)
            2'd0: r = a | b;
            2'd1: begin res = sa + sb; r = 16'(res); ov = (res > 32767) || (res < -32768); end
            2'd2: begin res = sa - sb; r = 16'(res); ov = (res > 32767) || (res < -32768); end
            default: begin
                res = sa - sb;
                ov  = (res > 32767) || (res < -32768);
                r   = (sa < sb) ? 16'd1 : 16'd0;
            end
        endcase
    endfunction

    // Reference model state
    logic [15:0] m_stk[$];
    int          m_busy = 0;
    logic        m_rv, m_fov, m_fz, m_ef, m_ee, m_eo;
    logic [15:0] m_rd, m_a, m_b, p_r;
    logic [1:0]  m_op;
    logic        p_ov;

    // Model update: an ALU command completes on the third edge after acceptance,
    // flags become visible one edge earlier
    always @(posedge clk) begin
        if (reset) begin
            m_stk.delete();
            m_busy = 0;
            m_rv = 0; m_rd = '0; m_a = '0; m_b = '0; m_op = '0;
            m_fov = 0; m_fz = 0; m_ef = 0; m_ee = 0; m_eo = 0;
        end else begin
            m_rv = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 1) begin
                    m_fov = p_ov;
                    m_fz  = (p_r == 16'd0);
                end
                if (m_busy == 0) begin
                    if (TRAP && (m_op == 2'd1 || m_op == 2'd2) && p_ov) begin
                        m_eo = 1;
                    end else begin
                        void'(m_stk.pop_back());
                        void'(m_stk.pop_back());
                        m_stk.push_back(p_r);
                        m_rv = 1;
                        m_rd = p_r;
                    end
                end
            end else if (cmd_valid) begin
                case (cmd)
                    2'd0: if (m_stk.size() < DEPTH) m_stk.push_back(cmd_data); else m_ef = 1;
                    2'd1: if (m_stk.size() > 0) begin m_rv = 1; m_rd = m_stk.pop_back(); end else m_ee = 1;
                    2'd2: begin
                        if (m_stk.size() < 2) m_ee = 1;
                        else begin
                            m_a  = m_stk[m_stk.size()-2];
                            m_b  = m_stk[m_stk.size()-1];
                            m_op = cmd_aluop;
                            ref_alu(m_op, m_a, m_b, p_r, p_ov);
                            m_busy = 3;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", cmd_ready, m_busy == 0);
            check("rsp_valid", rsp_valid, m_rv);
            if (m_rv) check("rsp_data", rsp_data, m_rd);
            check("depth", depth, m_stk.size());
            check("flag_ovflw", flag_ovflw, m_fov);
            check("flag_zero", flag_zero, m_fz);
            check("err_full", err_full, m_ef);
            check("err_empty", err_empty, m_ee);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_op", alu_op, m_op);
`ifdef ALU_OVFLW_TRAP_EN
            check("err_ovflw", err_ovflw, m_eo);
`endif
        end
    end

    // All directed tasks start and end one time unit after a rising edge
    task automatic issue(input logic [1:0] c, input logic [1:0] op, input logic [15:0] d);
        bit ok;
        ok = 0;
        cmd = c; cmd_aluop = op; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int maxc, output int lat, output logic [15:0] d);
        lat = -1;
        d   = '0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = i; d = rsp_data; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_alu(input logic [1:0] op, input logic [15:0] exp, input string name);
        int lat;
        logic [15:0] d;
        issue(2'd2, op, '0);
        wait_rsp(8, lat, d);
        check({name, "_lat"}, lat, 4);
        check({name, "_data"}, d, exp);
    endtask

    task automatic do_pop(input logic [15:0] exp, input string name);
        int lat;
        logic [15:0] d;
        issue(2'd1, '0, '0);
        wait_rsp(4, lat, d);
        check({name, "_lat"}, lat, 1);
        check({name, "_data"}, d, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [15:0] d;
        reset = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_aluop = '0; cmd_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_depth", depth, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_alu", {alu_a, alu_b}, 0);
        @(posedge clk); #1;

        issue(2'd0, '0, 16'd5);
        issue(2'd0, '0, 16'd3);
        do_alu(2'd1, 16'd8, "add_5_3");
        check("add_depth", depth, 1);
        check("add_zero", flag_zero, 0);
        do_pop(16'd8, "pop_8");
        check("pop_depth", depth, 0);

        issue(2'd0, '0, 16'hFF00);
        issue(2'd0, '0, 16'hFF00);
        do_alu(2'd2, 16'd0, "sub_eq");
        check("sub_zero", flag_zero, 1);
        do_pop(16'd0, "pop_sub");
        issue(2'd0, '0, 16'd7);
        issue(2'd0, '0, 16'd9);
        do_alu(2'd3, 16'd1, "slt_7_9");
        do_pop(16'd1, "pop_slt1");
        issue(2'd0, '0, 16'd9);
        issue(2'd0, '0, 16'd7);
        do_alu(2'd3, 16'd0, "slt_9_7");
        do_pop(16'd0, "pop_slt0");

        issue(2'd0, '0, 16'h00F0);
        issue(2'd0, '0, 16'h0F00);
        do_alu(2'd0, 16'h0FF0, "or");
        do_pop(16'h0FF0, "pop_or");

        issue(2'd0, '0, 16'h7FFF);
        issue(2'd0, '0, 16'h0001);
`ifdef ALU_OVFLW_TRAP_EN
        issue(2'd2, 2'd1, '0);
        wait_rsp(6, lat, d);
        check("trap_no_rsp", lat, -1);
        check("trap_depth", depth, 2);
        check("trap_err", err_ovflw, 1);
        check("trap_flag", flag_ovflw, 1);
        do_pop(16'h0001, "trap_pop_b");
        do_pop(16'h7FFF, "trap_pop_a");
`else
        do_alu(2'd1, 16'h8000, "ovf_add");
        check("ovf_depth", depth, 1);
        check("ovf_flag", flag_ovflw, 1);
        do_pop(16'h8000, "pop_ovf");
`endif

        for (int i = 0; i < DEPTH; i++) issue(2'd0, '0, 16'(16'h100 + i));
        issue(2'd0, '0, 16'hDEAD);
        check("full_err", err_full, 1);
        check("full_depth", depth, 16);
        for (int i = DEPTH - 1; i >= 0; i--) do_pop(16'(16'h100 + i), "lifo");
        issue(2'd1, '0, '0);
        wait_rsp(3, lat, d);
        check("empty_no_rsp", lat, -1);
        check("empty_err", err_empty, 1);

        do_reset();
        issue(2'd0, '0, 16'd1);
        issue(2'd2, 2'd1, '0);
        @(negedge clk);
        check("alu1_err", err_empty, 1);
        check("alu1_ready", cmd_ready, 1);
        check("alu1_depth", depth, 1);
        @(posedge clk); #1;

        // reset while the ALU command sits in EXEC
        do_reset();
        issue(2'd0, '0, 16'd11);
        issue(2'd0, '0, 16'd22);
        issue(2'd2, 2'd1, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_rsp(6, lat, d);
        check("rst_exec_no_rsp", lat, -1);
        check("rst_exec_depth", depth, 0);
        check("rst_exec_flags", {flag_ovflw, flag_zero, err_full, err_empty}, 0);
        check("rst_exec_alu", {alu_a, alu_b, 14'd0, alu_op}, 0);
        check("rst_exec_rsp_data", rsp_data, 0);

        // held command accepted on the response cycle
        issue(2'd0, '0, 16'd4);
        issue(2'd0, '0, 16'd6);
        issue(2'd2, 2'd1, '0);
        cmd = 2'd1; cmd_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("busy_ready", cmd_ready, 0);
        end
        @(negedge clk);
        check("held_ready", cmd_ready, 1);
        check("held_rsp_valid", rsp_valid, 1);
        check("held_rsp_data", rsp_data, 16'd10);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(4, lat, d);
        check("held_pop_lat", lat, 1);
        check("held_pop_data", d, 16'd10);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int sel;
            reset     = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 3) != 0);
            sel       = int'($urandom_range(0, 9));
            cmd       = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            cmd_aluop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: cmd_data = 16'h7FFF;
                1: cmd_data = 16'h8000;
                2: cmd_data = 16'h0000;
                3: cmd_data = 16'hFFFF;
                default: cmd_data = 16'($urandom);
            endcase
            @(posedge clk); #1;
        end
        reset = 1'b0;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
